bus_transceiver_ctrl: RTL and testbench

//  Owns one end of the shared tristate data bus; the opposite end is driven by a peer transceiver.

---
 rtl/bus_transceiver_ctrl_if.sv | 13 +
 rtl/bus_transceiver_ctrl.sv | 82 ++++++++
 tb/tb_bus_transceiver_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/bus_transceiver_ctrl_if.sv
// bus_transceiver_ctrl_if: handshake, strobe and status signals of one bus transceiver end.
interface bus_transceiver_ctrl_if #(parameter int WIDTH = 4);
    logic             tx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             peer_oe;
    logic             bus_oe;
    logic             coll_err;
    modport master (output tx_valid, tx_data, peer_oe, input tx_ready, rx_data, rx_valid, bus_oe, coll_err);
    modport slave  (input tx_valid, tx_data, peer_oe, output tx_ready, rx_data, rx_valid, bus_oe, coll_err);
endinterface

// File: rtl/bus_transceiver_ctrl.sv
// bus_transceiver_ctrl: half-duplex tristate bus end with turnaround, burst limit and peer priority.
// Defining COLLISION_DET_EN enables sticky collision detection while driving.
module bus_transceiver_ctrl #(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4,
    parameter int TURN_CYC  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    inout  wire  [WIDTH-1:0]      io_bus,
    bus_transceiver_ctrl_if.slave sif
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(TURN_CYC + 1);
    typedef enum logic [1:0] {IDLE, DRIVE, TURN, LISTEN} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_dout, r_rx_data;
    logic [BW-1:0]    r_burst_cnt;
    logic [TW-1:0]    r_turn_cnt;
    logic             r_bus_oe, r_rx_valid, r_coll_err;
    logic             w_coll, w_accept, w_capture, w_turn_done;
`ifdef COLLISION_DET_EN
    assign w_coll = r_state == DRIVE && sif.peer_oe;
`else
    assign w_coll = 1'b0;
`endif
    assign sif.tx_ready = (r_state == IDLE && !sif.peer_oe) ||
                          (r_state == DRIVE && r_burst_cnt < BW'(MAX_BURST) && !w_coll);
    assign w_accept     = sif.tx_valid && sif.tx_ready;
    // The peer's first word is already on the bus in the IDLE cycle that sees peer_oe.
    assign w_capture    = (r_state == IDLE || r_state == LISTEN) && sif.peer_oe;
    assign w_turn_done  = r_turn_cnt == TW'(TURN_CYC - 1);
    assign io_bus       = r_bus_oe ? r_dout : 'z;
    assign sif.bus_oe   = r_bus_oe;
    assign sif.rx_data  = r_rx_data;
    assign sif.rx_valid = r_rx_valid;
    assign sif.coll_err = r_coll_err;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bus_oe    <= 1'b0;
            r_dout      <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_coll_err  <= 1'b0;
            r_burst_cnt <= '0;
            r_turn_cnt  <= '0;
        end else begin
            r_rx_valid <= w_capture;
            if (w_capture) r_rx_data <= io_bus;
            if (w_accept) begin
                r_dout      <= sif.tx_data;
                r_burst_cnt <= r_burst_cnt + BW'(1);
            end
            case (r_state)
                IDLE: begin
                    if (sif.peer_oe) r_state <= LISTEN;
                    else if (sif.tx_valid) begin
                        r_state  <= DRIVE;
                        r_bus_oe <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (!w_accept) begin
                        r_state    <= TURN;
                        r_bus_oe   <= 1'b0;
                        r_coll_err <= r_coll_err | w_coll;
                    end
                end
                TURN: begin
                    r_turn_cnt <= w_turn_done ? '0 : r_turn_cnt + TW'(1);
                    if (w_turn_done) begin
                        r_state     <= IDLE;
                        r_burst_cnt <= '0;
                    end
                end
                LISTEN: if (!sif.peer_oe) r_state <= TURN;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_transceiver_ctrl.sv
// tb_bus_transceiver_ctrl: directed stimulus, tenure-level reference model checked every cycle.
module tb_bus_transceiver_ctrl;
    localparam int W = 4, MB = 4, TC = 1;
`ifdef COLLISION_DET_EN
    localparam bit COLL = 1'b1;
`else
    localparam bit COLL = 1'b0;
`endif
    logic         clk = 1'b0, rst = 1'b1;
    logic [W-1:0] peer_data = '0;
    wire  [W-1:0] bus;
    int           checks = 0, errors = 0;
    bus_transceiver_ctrl_if #(.WIDTH(W)) sif();
    bus_transceiver_ctrl #(.WIDTH(W), .MAX_BURST(MB), .TURN_CYC(TC)) dut (
        .clk(clk), .rst(rst), .io_bus(bus), .sif(sif)
    );
    assign bus = sif.peer_oe ? peer_data : 'z;
    always #5 clk = ~clk;
    // Model: who owns the bus, words in this tenure, released cycles still owed.
    bit           m_ours, m_peer, m_rxv, m_coll, armed;
    int           m_words, m_quiet;
    logic [W-1:0] m_dout, m_rx;
    function automatic bit exp_ready();
        return (!m_ours && !m_peer && m_quiet == 0 && !sif.peer_oe) ||
               (m_ours && m_words < MB && !(COLL && sif.peer_oe));
    endfunction
    task automatic chk(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", n, a, e, $time);
        end
    endtask
    task automatic model_update();
        bit acc;
        acc   = sif.tx_valid && exp_ready();
        m_rxv = 1'b0;
        if (rst) begin
            {m_ours, m_peer, m_coll} = '0;
            m_words = 0;
            m_quiet = 0;
            m_dout  = '0;
            m_rx    = '0;
            armed   = 1'b1;
        end else if (m_ours) begin
            if (COLL && sif.peer_oe) begin
                m_coll  = 1'b1;
                m_ours  = 1'b0;
                m_quiet = TC;
            end else if (acc) begin
                m_dout = sif.tx_data;
                m_words++;
            end else begin
                m_ours  = 1'b0;
                m_quiet = TC;
            end
        end else if (m_peer) begin
            if (sif.peer_oe) begin
                m_rx  = peer_data;
                m_rxv = 1'b1;
            end else begin
                m_peer  = 1'b0;
                m_quiet = TC;
            end
        end else if (m_quiet > 0) begin
            m_quiet--;
        end else if (sif.peer_oe) begin
            m_peer = 1'b1;
            m_rx   = peer_data;
            m_rxv  = 1'b1;
        end else if (sif.tx_valid) begin
            m_ours  = 1'b1;
            m_words = 1;
            m_dout  = sif.tx_data;
        end
    endtask
    task automatic compare();
        if (!armed) return;
        chk("bus_oe", W'(sif.bus_oe), W'(m_ours));
        chk("rx_valid", W'(sif.rx_valid), W'(m_rxv));
        chk("rx_data", sif.rx_data, m_rx);
        chk("tx_ready", W'(sif.tx_ready), W'(exp_ready()));
        chk("coll_err", W'(sif.coll_err), W'(m_coll));
        if (m_ours && !sif.peer_oe) chk("bus", bus, m_dout);
    endtask
    task automatic cyc();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask
    task automatic drive(input bit v, input logic [W-1:0] d, input bit p, input logic [W-1:0] pd);
        sif.tx_valid = v;
        sif.tx_data  = d;
        sif.peer_oe  = p;
        peer_data    = pd;
    endtask
    initial begin
        drive(0, '0, 0, '0);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        chk("t1_bus_oe", W'(sif.bus_oe), '0);
        chk("t1_rx_valid", W'(sif.rx_valid), '0);
        chk("t1_rx_data", sif.rx_data, 4'b0000);
        chk("t1_tx_ready", W'(sif.tx_ready), 4'd1);
        drive(1, 4'b0011, 0, '0);
        cyc();
        chk("t2_bus_oe", W'(sif.bus_oe), 4'd1);
        chk("t2_bus", bus, 4'b0011);
        drive(0, '0, 0, '0);
        cyc();
        chk("t2_turn_oe", W'(sif.bus_oe), '0);
        chk("t2_turn_ready", W'(sif.tx_ready), '0);
        cyc();
        chk("t2_idle_ready", W'(sif.tx_ready), 4'd1);
        for (int i = 1; i <= 4; i++) begin
            drive(1, W'(i), 0, '0);
            cyc();
            chk("t3_bus", bus, W'(i));
        end
        drive(1, 4'd5, 0, '0);
        #1 chk("t3_full_ready", W'(sif.tx_ready), '0);
        cyc();
        chk("t3_turn_oe", W'(sif.bus_oe), '0);
        cyc();
        chk("t3_idle_ready", W'(sif.tx_ready), 4'd1);
        cyc();
        chk("t3_bus5", bus, 4'd5);
        drive(0, '0, 0, '0);
        cyc();
        cyc();
        drive(0, '0, 1, 4'b1010);
        cyc();
        chk("t4_rxv0", W'(sif.rx_valid), 4'd1);
        chk("t4_rx0", sif.rx_data, 4'b1010);
        drive(0, '0, 1, 4'b1110);
        cyc();
        chk("t4_rxv1", W'(sif.rx_valid), 4'd1);
        chk("t4_rx1", sif.rx_data, 4'b1110);
        chk("t4_oe", W'(sif.bus_oe), '0);
        drive(0, '0, 0, '0);
        cyc();
        chk("t4_rxv_end", W'(sif.rx_valid), '0);
        cyc();
        drive(1, 4'b1001, 1, 4'b0101);
        #1 chk("t5_ready", W'(sif.tx_ready), '0);
        cyc();
        chk("t5_rx", sif.rx_data, 4'b0101);
        chk("t5_oe", W'(sif.bus_oe), '0);
        drive(1, 4'b1001, 0, '0);
        cyc();
        cyc();
        cyc();
        chk("t5_bus", bus, 4'b1001);
        drive(0, '0, 0, '0);
        cyc();
        cyc();
        drive(1, 4'b1100, 0, '0);
        cyc();
        chk("t6_bus", bus, 4'b1100);
        drive(1, 4'b1100, 1, 4'b0000);
        #1 chk("t6_ready", W'(sif.tx_ready), W'(!COLL));
        cyc();
        chk("t6_oe", W'(sif.bus_oe), W'(!COLL));
        chk("t6_coll", W'(sif.coll_err), W'(COLL));
        drive(0, '0, 0, '0);
        for (int i = 0; i < 4; i++) cyc();
        chk("t6_sticky", W'(sif.coll_err), W'(COLL));
        drive(1, 4'b0110, 0, '0);
        cyc();
        chk("rst_mid_oe", W'(sif.bus_oe), 4'd1);
        rst = 1'b1;
        cyc();
        chk("rst_mid_release", W'(sif.bus_oe), '0);
        chk("rst_coll_clr", W'(sif.coll_err), '0);
        rst = 1'b0;
        drive(0, '0, 0, '0);
        cyc();
        chk("rst_idle_ready", W'(sif.tx_ready), 4'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
